// File: rtl/fx2_pkg.sv
// Shared types and constants for the FX2LP slave-FIFO writer.
package fx2_pkg;

    typedef enum logic [1:0] {
        StStream = 2'd0,
        StDrain  = 2'd1,
        StPktend = 2'd2,
        StHold   = 2'd3
    } fx2_state_e;

    localparam int unsigned PktBytesDefault = 512;

endpackage

// File: rtl/sync_fifo_8.sv
// Byte-wide synchronous FIFO with occupancy; push while full is taken only alongside a pop.
module sync_fifo_8 #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [7:0]            wdata_i,
    input  logic                  pop_i,
    output logic [7:0]            rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    logic [7:0]            mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  push_ok, pop_ok;

    // Level is at most Depth, so its MSB alone marks full.
    assign full_o  = level_q[DEPTH_LOG2];
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fx2_fifo_writer.sv
// Buffers the decimated sample stream and drives the FX2LP slave-FIFO write port,
// with host-requested short-packet commit via PKTEND and sticky overflow reporting.
module fx2_fifo_writer
    import fx2_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned PKT_BYTES  = PktBytesDefault
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [7:0]          in_data_i,
    input  logic                in_valid_i,
    input  logic                flush_i,
    input  logic                clr_ovf_i,
    input  logic                fulln_i,
    output logic [7:0]          fd_o,
    output logic                slwrn_o,
    output logic                pktendn_o,
    output logic                overflow_o,
    output logic [DEPTH_LOG2:0] level_o
);

    localparam int unsigned CntW = $clog2(PKT_BYTES);

    fx2_state_e      state_q, state_d;
    logic [7:0]      fd_q, fd_d;
    logic            slwrn_q, slwrn_d;
    logic            pktendn_q, pktendn_d;
    logic            overflow_q, overflow_d;
    logic            flush_pend_q, flush_pend_d;
    logic [CntW-1:0] byte_cnt_q, byte_cnt_d;

    logic            fifo_full, fifo_empty;
    logic [7:0]      fifo_head;
    logic            pop, push, cnt_wrap;

    sync_fifo_8 #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (in_data_i),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    always_comb begin
        // HOLD's own visible cycle is idle; its exit decision follows the normal write rule.
        pop      = enable_i && fulln_i && !fifo_empty && (state_q != StPktend);
        push     = in_valid_i && (!fifo_full || pop);
        cnt_wrap = (byte_cnt_q == CntW'(PKT_BYTES - 1));

        state_d      = state_q;
        fd_d         = fd_q;
        slwrn_d      = 1'b1;
        pktendn_d    = 1'b1;
        byte_cnt_d   = byte_cnt_q;
        flush_pend_d = flush_pend_q || flush_i;
        overflow_d   = (overflow_q && !clr_ovf_i) || (in_valid_i && !push);

        if (pop) begin
            slwrn_d    = 1'b0;
            fd_d       = fifo_head;
            byte_cnt_d = cnt_wrap ? '0 : byte_cnt_q + 1'b1;
        end

        if (enable_i) begin
            unique case (state_q)
                StStream: begin
                    if (flush_pend_q) begin
                        // Nothing uncommitted (or FX2 auto-commits now): no zero-length packet.
                        if (byte_cnt_q == '0 || (pop && cnt_wrap)) begin
                            flush_pend_d = 1'b0;
                        end else begin
                            state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (pop && cnt_wrap) begin
                        flush_pend_d = 1'b0;
                        state_d      = StStream;
                    end else if (fifo_empty && fulln_i) begin
                        pktendn_d    = 1'b0;
                        byte_cnt_d   = '0;
                        flush_pend_d = 1'b0;
                        state_d      = StPktend;
                    end
                end
                StPktend: state_d = StHold;
                StHold:   state_d = StStream;
                default:  state_d = StStream;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StStream;
            fd_q         <= '0;
            slwrn_q      <= 1'b1;
            pktendn_q    <= 1'b1;
            overflow_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            fd_q         <= fd_d;
            slwrn_q      <= slwrn_d;
            pktendn_q    <= pktendn_d;
            overflow_q   <= overflow_d;
            flush_pend_q <= flush_pend_d;
            byte_cnt_q   <= byte_cnt_d;
        end
    end

    assign fd_o       = fd_q;
    assign slwrn_o    = slwrn_q;
    assign pktendn_o  = pktendn_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_fx2_fifo_writer.sv
// Directed bench for fx2_fifo_writer: streaming, overflow, flush/PKTEND, wrap and reset.
module tb_fx2_fifo_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       fulln = 1'b1;
    logic [7:0] fd;
    logic       slwrn, pktendn, overflow;
    logic [4:0] level;

    int checks = 0;
    int failures = 0;
    logic [7:0] wr_q [$];
    int pkt_n = 0;

    fx2_fifo_writer #(
        .DEPTH_LOG2(4),
        .PKT_BYTES (512)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .enable_i   (enable),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .flush_i    (flush),
        .clr_ovf_i  (clr_ovf),
        .fulln_i    (fulln),
        .fd_o       (fd),
        .slwrn_o    (slwrn),
        .pktendn_o  (pktendn),
        .overflow_o (overflow),
        .level_o    (level)
    );

    always #5 clk = ~clk;

    // Log every FX2 write byte and PKTEND pulse seen on the bus.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!slwrn) wr_q.push_back(fd);
            if (!pktendn) pkt_n++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int b;
        int p0;
        int errs;

        #12;
        check("rst_slwrn", slwrn, 1);
        check("rst_pktendn", pktendn, 1);
        check("rst_fd", fd, 0);
        check("rst_ovf", overflow, 0);
        check("rst_level", level, 0);
        rst_n = 1'b1;
        #3;
        enable = 1'b1;
        fulln  = 1'b1;
        tick();

        // 1: three back-to-back bytes, one-cycle latency
        b = wr_q.size();
        in_valid = 1'b1; in_data = 8'h11; tick();
        check("t1_lat_slwrn", slwrn, 1);
        check("t1_lat_level", level, 1);
        in_data = 8'h22; tick();
        check("t1_w0_slwrn", slwrn, 0);
        check("t1_w0_fd", fd, 8'h11);
        in_data = 8'h33; tick();
        check("t1_w1_fd", fd, 8'h22);
        in_valid = 1'b0; tick();
        check("t1_w2_fd", fd, 8'h33);
        check("t1_w2_slwrn", slwrn, 0);
        check("t1_level", level, 0);
        tick();
        check("t1_idle_slwrn", slwrn, 1);
        check("t1_hold_fd", fd, 8'h33);
        check("t1_nwr", wr_q.size() - b, 3);

        // 2: endpoint full, overflow, set-wins, push+pop when full
        fulln = 1'b0;
        b = wr_q.size();
        for (int i = 0; i < 20; i++) push_byte(8'h40 + 8'(i));
        check("t2_level", level, 16);
        check("t2_ovf", overflow, 1);
        check("t2_slwrn", slwrn, 1);
        in_valid = 1'b1; in_data = 8'hEE; clr_ovf = 1'b1; tick();
        in_valid = 1'b0;
        check("t2_setwins", overflow, 1);
        tick();
        clr_ovf = 1'b0;
        check("t2_clr", overflow, 0);
        fulln = 1'b1;
        push_byte(8'h99);
        check("t2_fullpush_ovf", overflow, 0);
        check("t2_fullpush_lvl", level, 16);
        repeat (18) tick();
        check("t2_nwr", wr_q.size() - b, 17);
        errs = 0;
        for (int i = 0; i < 17; i++) begin
            if (b + i < wr_q.size() && wr_q[b + i] !== ((i < 16) ? 8'h40 + 8'(i) : 8'h99)) errs++;
        end
        check("t2_data", errs, 0);
        check("t2_level_end", level, 0);

        // 3: short packet commit (count 20 -> 25)
        p0 = pkt_n;
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
        flush = 1'b1; tick(); flush = 1'b0;
        check("t3_last_fd", fd, 8'hC4);
        check("t3_last_slwrn", slwrn, 0);
        tick();
        check("t3_drain_pktendn", pktendn, 1);
        tick();
        check("t3_pktendn", pktendn, 0);
        check("t3_pkt_slwrn", slwrn, 1);
        tick();
        check("t3_hold_pktendn", pktendn, 1);
        check("t3_hold_slwrn", slwrn, 1);
        repeat (3) tick();
        check("t3_npkt", pkt_n - p0, 1);

        // 4: flush with zero count yields no packet
        p0 = pkt_n;
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (6) tick();
        check("t4_npkt", pkt_n - p0, 0);

        // 5: 510 bytes, then flush with 4 queued: auto-commit wrap, no PKTEND
        b = wr_q.size();
        p0 = pkt_n;
        in_valid = 1'b1;
        for (int i = 0; i < 510; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("t5_n510", wr_q.size() - b, 510);
        errs = 0;
        for (int i = 0; i < 510; i++) begin
            if (b + i < wr_q.size() && wr_q[b + i] !== 8'(i)) errs++;
        end
        check("t5_data", errs, 0);
        fulln = 1'b0;
        in_valid = 1'b1; flush = 1'b1; in_data = 8'hA0; tick();
        flush = 1'b0;
        for (int i = 1; i < 4; i++) begin
            in_data = 8'hA0 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("t5_queued", level, 4);
        fulln = 1'b1;
        repeat (8) tick();
        check("t5_n514", wr_q.size() - b, 514);
        check("t5_npkt", pkt_n - p0, 0);
        if (b + 513 < wr_q.size()) check("t5_tail", wr_q[b + 513], 8'hA3);
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (6) tick();
        check("t5_next_pkt", pkt_n - p0, 1);

        // 6: reset during DRAIN with 8 queued
        push_byte(8'h01);
        repeat (3) tick();
        fulln = 1'b0;
        p0 = pkt_n;
        for (int i = 0; i < 8; i++) begin
            flush = (i == 7);
            push_byte(8'h80 + 8'(i));
        end
        flush = 1'b0;
        repeat (3) tick();
        check("t6_level8", level, 8);
        check("t6_pre_pktendn", pktendn, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_slwrn", slwrn, 1);
        check("t6_rst_pktendn", pktendn, 1);
        check("t6_rst_level", level, 0);
        check("t6_rst_fd", fd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fulln = 1'b1;
        tick();
        push_byte(8'h5A);
        check("t6_lat", slwrn, 1);
        tick();
        check("t6_slwrn", slwrn, 0);
        check("t6_fd", fd, 8'h5A);
        repeat (4) tick();
        check("t6_npkt", pkt_n - p0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fx2_fifo_writer.md
Name: fx2_fifo_writer

Overview:
Downstream stage of the ADC capture path. Accepts the decimated 8-bit sample stream, buffers it in a small synchronous FIFO, and drives the FX2LP slave-FIFO write interface (FD, SLWRN, PKTENDN), honouring the FX2 full flag. Supports host-commanded flush of short packets via PKTEND, and reports overflow when samples arrive faster than the FX2 can drain them. Lives in the IFCLK domain inside the top level.

Parameters:
DEPTH_LOG2, 4, log2 of internal FIFO depth (16 entries)
PKT_BYTES, 512, FX2 endpoint packet size in bytes; auto-commit boundary

Ports:
CLK  in  1  IFCLK (48 MHz), all logic on rising edge
RESET_N  in  1  asynchronous, active-low reset
ENABLE  in  1  permits writes to FX2; FIFO still fills when low
IN_DATA  in  8  sample byte
IN_VALID  in  1  sample strobe, one byte per cycle max, no backpressure
FLUSH  in  1  single-cycle request to commit a short packet
CLR_OVF  in  1  clears OVERFLOW
FULLN  in  1  FX2 FLAGN[1]; 1 = endpoint not full
FD  out  8  FX2 data bus (write direction only)
SLWRN  out  1  FX2 write strobe, active low
PKTENDN  out  1  FX2 packet end, active low
OVERFLOW  out  1  sticky: a sample was dropped
LEVEL  out  DEPTH_LOG2+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): SLWRN=1, PKTENDN=1, FD=0, OVERFLOW=0, LEVEL=0, FIFO empty, byte count 0, flush_pending=0, state STREAM.
- FD, SLWRN, PKTENDN are registered; decision at edge n is visible after edge n.
- Push: IN_VALID=1 is accepted if FIFO not full, or if full and a pop occurs in the same cycle. Otherwise the byte is dropped and OVERFLOW is set. OVERFLOW clears on CLR_OVF; if set and clear coincide, set wins.
- Pop/write (state STREAM): when ENABLE=1, FULLN=1 and FIFO not empty, register SLWRN=0 and FD=head, then pop. Otherwise SLWRN=1 and FD holds its last value. Back-to-back writes run at one byte per cycle.
- Latency: byte accepted at edge k into an empty FIFO (ENABLE=1, FULLN=1) appears on FD with SLWRN=0 after edge k+1.
- Byte count: increments per write and wraps PKT_BYTES-1 -> 0, because the FX2 auto-commits the packet.
- FLUSH sets flush_pending. Further FLUSH while pending has no additional effect.
- States:
  - STREAM: normal operation. If flush_pending and byte count == 0, clear flush_pending and stay (no zero-length packet). If flush_pending and count != 0, go to DRAIN.
  - DRAIN: keep writing per the pop rule. When FIFO empty, go to PKTEND. If count wraps to 0 in DRAIN, clear pending and return to STREAM.
  - PKTEND: one cycle of PKTENDN=0 with SLWRN=1. Byte count -> 0, flush_pending=0, go to HOLD. Requires FULLN=1; otherwise wait in DRAIN.
  - HOLD: one idle cycle (SLWRN=1, PKTENDN=1) for FX2 flag settling, then STREAM.
- Pushes continue during DRAIN, PKTEND and HOLD. Bytes pushed during DRAIN are drained before PKTEND.
- ENABLE=0: no writes and no PKTEND. State and flush_pending are retained.
- FULLN falling mid-burst: the write stops the next decision cycle. The FX2 flag latency margin is owned by the firmware's programmable-flag setting.
- Reset mid-operation: immediate return to reset values; buffered data is discarded.

Decomposition:
- Package fx2_pkg: state enum (STREAM, DRAIN, PKTEND, HOLD) and default PKT_BYTES constant.
- Sub-module sync_fifo_8: byte-wide, DEPTH_LOG2-parameterised FIFO with push/pop, full/empty and level. Same-cycle push+pop when full is legal.

Test Plan:
1. Reset, then ENABLE=1, FULLN=1, push 0x11,0x22,0x33 on consecutive cycles -> SLWRN=0 for 3 cycles starting one cycle after the first push; FD=0x11,0x22,0x33; LEVEL returns to 0.
2. FULLN=0, push 20 bytes (depth 16) -> first 16 retained, LEVEL=16, OVERFLOW=1, SLWRN stays 1. Then FULLN=1 -> 16 writes, FD=bytes 0..15. CLR_OVF -> OVERFLOW=0.
3. Write 5 bytes, then pulse FLUSH -> after the FIFO drains, one cycle PKTENDN=0 with SLWRN=1, then one HOLD cycle, then byte count=0.
4. FLUSH with byte count 0 -> no PKTENDN pulse; flush_pending clears.
5. Write 510 bytes, then FLUSH while 4 more are queued -> count wraps at 512, no PKTENDN, next packet starts with 2 bytes.
6. Assert RESET_N low during DRAIN with LEVEL=8 -> SLWRN=1, PKTENDN=1, LEVEL=0 immediately. After release, the first push is written normally.
